// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

  localparam int BITS_PER_BYTE          = 8;
  localparam int DEFAULT_CYCLES_PER_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // next values: shift the raw input through both stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // synchronizer flops, reset to the line's idle level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled at cycles_per_bit clocks per bit.
// Optional running byte checksum output enabled by macro UART_RX_CHECKSUM_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a low level (start bit)
// ST_START | waiting half a bit to re-check the start bit mid-bit
// ST_DATA  | sampling 8 data bits mid-bit, one per bit period
// ST_STOP  | sampling the stop bit; high = good frame, low = error
// ST_BREAK | stop bit was low; waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int cycles_per_bit = DEFAULT_CYCLES_PER_BIT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ser_in,
`ifdef UART_RX_CHECKSUM_EN
  output logic [31:0] checksum,
`endif
  output logic [7:0]  data_out,
  output logic        valid,
  output logic        frame_error,
  output logic        busy
);

  localparam int TW = (cycles_per_bit > 1) ? $clog2(cycles_per_bit) : 1;
  // Down-counter reload values: terminal count is zero, so load N-1 for N cycles.
  localparam logic [TW-1:0] T_BIT  = TW'(cycles_per_bit - 1);
  localparam logic [TW-1:0] T_HALF = TW'(cycles_per_bit / 2 - 1);
  localparam logic [3:0]    LAST_BIT = 4'(BITS_PER_BYTE - 1);

  logic rx_s;

  uart_rx_state_t state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           load_q, load_d;
  logic           err_q, err_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           tc;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (ser_in),
    .q       (rx_s)
  );

  assign tc = (timer_q == '0);

  // frame FSM: timer reloads on each sample, counts down otherwise
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    load_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d   = ST_START;
          timer_d   = T_HALF;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tc) begin
          if (!rx_s) begin
            state_d = ST_DATA;
            timer_d = T_BIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (tc) begin
          shift_d = {rx_s, shift_q[7:1]};
          timer_d = T_BIT;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = ST_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (tc) begin
          if (rx_s) begin
            state_d = ST_IDLE;
            load_d  = 1'b1;
          end else begin
            state_d = ST_BREAK;
            err_d   = 1'b1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // output stage: the stop-bit verdict is published one cycle after sampling
  always_comb begin
    valid_d = load_q;
    ferr_d  = err_q;
    data_d  = load_q ? shift_q : data_q;
  end

  // state and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      load_q    <= load_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

`ifdef UART_RX_CHECKSUM_EN
  logic [31:0] cks_q, cks_d;

  // accumulate each accepted byte, wrapping modulo 2^32
  always_comb begin
    cks_d = load_q ? (cks_q + {24'h0, shift_q}) : cks_q;
  end

  // checksum accumulator register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cks_q <= '0;
    else          cks_q <= cks_d;
  end

  assign checksum = cks_q;
`endif

  assign data_out    = data_q;
  assign valid       = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at cycles_per_bit = 4.
// Checksum checks are compiled in when UART_RX_CHECKSUM_EN is defined.
module tb_uart_rx;

  localparam int CPB = 4;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       ser_in  = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_error;
  logic       busy;
`ifdef UART_RX_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int errors = 0;
  int checks = 0;

  int edge_cnt        = 0;
  int valid_cnt       = 0;
  int ferr_cnt        = 0;
  int both_cnt        = 0;
  int last_valid_edge = 0;
  int prev_valid_edge = 0;
  int last_ferr_edge  = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;

  uart_rx #(.cycles_per_bit(CPB)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ser_in      (ser_in),
`ifdef UART_RX_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .data_out    (data_out),
    .valid       (valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // edge counter and pulse recorder, sampling 1 ns after each rising edge
  always @(posedge clock) begin
    edge_cnt++;
    #1;
    if (valid) begin
      valid_cnt++;
      prev_valid_edge = last_valid_edge;
      prev_data       = last_data;
      last_valid_edge = edge_cnt;
      last_data       = data_out;
    end
    if (frame_error) begin
      ferr_cnt++;
      last_ferr_edge = edge_cnt;
    end
    if (valid && frame_error) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drive one 8N1 frame; start_edge is the edge that first samples the start bit
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int start_edge);
    start_edge = edge_cnt + 1;
    ser_in = 1'b0;
    repeat (CPB) @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) begin
      ser_in = b[i];
      repeat (CPB) @(posedge clock);
      #1;
    end
    ser_in = stop_bit;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  initial begin
    int s;
    int s2;
    int v0;
    int f0;

    // reset state
    #2;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(frame_error), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    // 0x55, latency 2 + 2 + 36 + 1 = 41
    send_byte(8'h55, 1'b1, s);
    repeat (3) @(posedge clock);
    #2;
    check("lat_55", last_valid_edge - s, 41);
    check("data_55", 32'(last_data), 32'h55);
    check("vcnt_55", valid_cnt, 1);
    check("ferr_55", ferr_cnt, 0);
    check("idle_55", 32'(busy), 32'h0);

    // one-cycle glitch: START entered two edges later, rejected at mid-bit
    v0 = valid_cnt;
    ser_in = 1'b0;
    @(posedge clock);
    #1 ser_in = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("glitch_busy", 32'(busy), 32'h1);
    repeat (6) @(posedge clock);
    #1;
    check("glitch_idle", 32'(busy), 32'h0);
    check("glitch_vcnt", valid_cnt, v0);
    check("glitch_ferr", ferr_cnt, 0);

    // 0xA3 with low stop bit: frame error, data held, busy until line high
    send_byte(8'hA3, 1'b0, s);
    repeat (2) @(posedge clock);
    #2;
    check("ferr_cnt", ferr_cnt, 1);
    check("ferr_lat", last_ferr_edge - s, 41);
    check("ferr_keep", 32'(data_out), 32'h55);
    check("ferr_vcnt", valid_cnt, v0);
    repeat (8) @(posedge clock);
    #1;
    check("break_busy", 32'(busy), 32'h1);
    ser_in = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("break_exit", 32'(busy), 32'h0);
    check("break_ferr1", ferr_cnt, 1);

    // back-to-back frames
    v0 = valid_cnt;
    send_byte(8'hA5, 1'b1, s);
    send_byte(8'h3C, 1'b1, s2);
    repeat (3) @(posedge clock);
    #2;
    check("b2b_vcnt", valid_cnt, v0 + 2);
    check("b2b_first", 32'(prev_data), 32'hA5);
    check("b2b_second", 32'(last_data), 32'h3C);
    check("b2b_gap", last_valid_edge - prev_valid_edge, 40);
    check("b2b_lat", last_valid_edge - s2, 41);
    check("no_overlap", both_cnt, 0);

    // reset during data bit 4 of 0xFF
    v0 = valid_cnt;
    f0 = ferr_cnt;
    ser_in = 1'b0;
    repeat (CPB) @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      ser_in = 1'b1;
      repeat (CPB) @(posedge clock);
      #1;
    end
    ser_in = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("pre_rst_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_ferr", 32'(frame_error), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (60) @(posedge clock);
    #1;
    check("rst_no_valid", valid_cnt, v0);
    check("rst_no_ferr", ferr_cnt, f0);
    send_byte(8'h12, 1'b1, s);
    repeat (3) @(posedge clock);
    #2;
    check("post_rst_data", 32'(data_out), 32'h12);
    check("post_rst_vcnt", valid_cnt, v0 + 1);

`ifdef UART_RX_CHECKSUM_EN
    reset_n = 1'b0;
    #1;
    check("cks_rst", checksum, 32'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    send_byte(8'h01, 1'b1, s);
    send_byte(8'h02, 1'b1, s);
    send_byte(8'hFF, 1'b1, s);
    repeat (3) @(posedge clock);
    #2;
    check("cks_sum", checksum, 32'h00000102);
    check("cks_data", 32'(data_out), 32'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
